// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for the sequential GF(2^WIDTH) multiplier.
// master drives operands and result acceptance; slave is the multiplier.
interface gf_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/gf_mult_seq.sv
// Shift-and-add GF(2^WIDTH) multiplier, one bit of b per clock; out_valid WIDTH cycles after accept.
// Result is held in DONE until out_ready; in_ready/out_valid are pure state decodes.
module gf_mult_seq #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
  input  logic         clk,
  input  logic         rst,
  gf_mult_seq_if.slave io_if
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic             w_last;

  // Carry-out of the shift is the pre-shift MSB; reduction happens in the same cycle.
  assign w_acc_nxt = r_b[0] ? (r_acc ^ r_a) : r_acc;
  assign w_a_nxt   = {r_a[WIDTH-2:0], 1'b0} ^ (r_a[WIDTH-1] ? POLY : '0);
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_if.in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)          w_state_nxt = S_DONE;
      S_DONE:  if (io_if.out_ready) w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_if.in_valid) begin
            r_a   <= io_if.a;
            r_b   <= io_if.b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_a   <= w_a_nxt;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_p <= w_acc_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_if.in_ready  = (r_state == S_IDLE);
  assign io_if.out_valid = (r_state == S_DONE);
  assign io_if.p         = r_p;

endmodule
